// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - multi-channel key debouncer with press, release and long-press pulses
module key_debounce_multi #(
  parameter int NUM_KEYS        = 3,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // Pin level of a released key; also the synchroniser reset value so reset never looks like a press
  localparam logic REL_LEVEL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          p;
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic          st_q;
    logic          press_q;
    logic          rel_q;
    logic          long_q;
    logic          accept_press;
    logic          accept_release;
    logic          holding;

    // Two-flop synchroniser for the asynchronous key pin
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= REL_LEVEL;
        sync2 <= REL_LEVEL;
      end else begin
        sync1 <= key_in[gi];
        sync2 <= sync1;
      end
    end

    // Normalise to active-high: p=1 means the key is pressed
    assign p              = sync2 ^ REL_LEVEL;
    assign accept_press   = (state == PRESS_DB) && p && (db_cnt == DB_LAST);
    assign accept_release = (state == RELEASE_DB) && !p && (db_cnt == DB_LAST);
    assign holding        = (state == HELD) || (state == RELEASE_DB);

    // Debounce FSM with registered level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        db_cnt  <= '0;
        st_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          IDLE: begin
            if (p) begin
              state  <= PRESS_DB;
              db_cnt <= '0;
            end
          end
          PRESS_DB: begin
            if (!p) begin
              state <= IDLE;
            end else if (db_cnt == DB_LAST) begin
              state   <= HELD;
              st_q    <= 1'b1;
              press_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!p) begin
              state  <= RELEASE_DB;
              db_cnt <= '0;
            end
          end
          RELEASE_DB: begin
            if (p) begin
              state <= HELD;
            end else if (db_cnt == DB_LAST) begin
              state <= IDLE;
              st_q  <= 1'b0;
              rel_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    if (LONG_CYCLES > 0) begin : g_long
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
      logic [HW-1:0] hold_cnt;

      // Saturating hold counter; saturation limits key_long to one pulse per press.
      // A release accepted on the same cycle wins so the pulses stay mutually exclusive.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (accept_press) begin
            hold_cnt <= '0;
          end else if (holding && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
            long_q   <= (hold_cnt == HOLD_PRE) && !accept_release;
          end
        end
      end
    end else begin : g_no_long
      assign long_q = 1'b0;
    end

    assign key_state[gi]   = st_q;
    assign key_press[gi]   = press_q;
    assign key_release[gi] = rel_q;
    assign key_long[gi]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed self-checking bench for key_debounce_multi
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [1:0] key_state;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;

  int checks = 0;
  int failures = 0;

  key_debounce_multi #(
    .NUM_KEYS(2),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lo(input int a, input int b);
    logic [63:0] r;
    r = '1;
    for (int i = a; i <= b; i++) r[i] = 1'b0;
    return r;
  endfunction

  // Drive channel 0 with pat[e] before edge e (1 = released pin) and check every edge.
  // pe/re/le are the edges where press/release/long must pulse (0 = never).
  task automatic play(input string tag, input logic [63:0] pat, input int n,
                      input int pe, input int re, input int le);
    logic st;
    for (int e = 1; e <= n; e++) begin
      key_in[0] = pat[e];
      tick();
      st = (pe != 0) && (e >= pe) && ((re == 0) || (e < re));
      check($sformatf("%s_e%0d_press", tag, e), 32'(key_press), {31'b0, e == pe});
      check($sformatf("%s_e%0d_release", tag, e), 32'(key_release), {31'b0, e == re});
      check($sformatf("%s_e%0d_long", tag, e), 32'(key_long), {31'b0, e == le});
      check($sformatf("%s_e%0d_state", tag, e), 32'(key_state), {31'b0, st});
    end
  endtask

  initial begin
    // Reset with keys released
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold_%0d", i), {24'b0, key_state, key_press, key_release, key_long}, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("idle_%0d", i), {24'b0, key_state, key_press, key_release, key_long}, 32'h0);
    end

    // Long press: press at 7, long at 17 only once, release at 37
    play("longpress", lo(1, 30), 40, 7, 37, 17);
    // Bounce on press, 3-cycle high glitch while held, then release
    play("bounce", lo(1, 3) & lo(6, 13) & lo(17, 24), 33, 12, 31, 22);
    // Short press: release with no long pulse
    play("short", lo(1, 6), 20, 7, 13, 0);
    // Pulse of exactly DEBOUNCE_CYCLES is rejected
    play("glitch_d", lo(1, 4), 15, 0, 0, 0);
    // Pulse of DEBOUNCE_CYCLES+1 is accepted
    play("glitch_d1", lo(1, 5), 15, 7, 12, 0);

    // Both keys on the same edge, released 3 cycles apart
    for (int e = 1; e <= 32; e++) begin
      if (e == 1) key_in = 2'b00;
      if (e == 20) key_in[0] = 1'b1;
      if (e == 23) key_in[1] = 1'b1;
      tick();
      check($sformatf("dual_e%0d_press", e), 32'(key_press), (e == 7) ? 32'h3 : 32'h0);
      check($sformatf("dual_e%0d_long", e), 32'(key_long), (e == 17) ? 32'h3 : 32'h0);
      check($sformatf("dual_e%0d_release", e), 32'(key_release),
            (e == 26) ? 32'h1 : ((e == 29) ? 32'h2 : 32'h0));
      check($sformatf("dual_e%0d_state", e), 32'(key_state),
            {30'b0, (e >= 7) && (e < 29), (e >= 7) && (e < 26)});
    end

    // Reset while channel 0 is in PRESS_DB, key held low through and after reset
    for (int i = 0; i < 5; i++) tick();
    key_in = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_now", {24'b0, key_state, key_press, key_release, key_long}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_mid_%0d", i), {24'b0, key_state, key_press, key_release, key_long}, 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 12) key_in[0] = 1'b1;
      tick();
      check($sformatf("rstp_e%0d_press", e), 32'(key_press), (e == 7) ? 32'h1 : 32'h0);
      check($sformatf("rstp_e%0d_long", e), 32'(key_long), (e == 17) ? 32'h1 : 32'h0);
      check($sformatf("rstp_e%0d_release", e), 32'(key_release), (e == 18) ? 32'h1 : 32'h0);
      check($sformatf("rstp_e%0d_state", e), 32'(key_state), {31'b0, (e >= 7) && (e < 18)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel key debouncer replacing the single-shot, shared-tick debouncer. Each channel runs its own synchroniser, debounce counter and four-state FSM. It produces a clean level, one-cycle press and release pulses, and a one-shot long-press pulse. The block sits between the board key pins and the application logic, with one instance per key group.

## Interface
- NUM_KEYS, 3: number of independent key channels (≥1).
- ACTIVE_LOW, 1: 1 = pressed key reads 0 on key_in; 0 = pressed key reads 1.
- DEBOUNCE_CYCLES, 1_000_000: cycles a new level must hold before it is accepted (20 ms at 50 MHz); ≥2.
- LONG_CYCLES, 50_000_000: cycles from accepted press to key_long (1 s at 50 MHz); 0 disables key_long; otherwise > DEBOUNCE_CYCLES.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_in  in  NUM_KEYS  raw asynchronous key pins.
- key_state  out  NUM_KEYS  debounced level, 1 = pressed, independent of ACTIVE_LOW.
- key_press  out  NUM_KEYS  one-cycle pulse on an accepted press.
- key_release  out  NUM_KEYS  one-cycle pulse on an accepted release.
- key_long  out  NUM_KEYS  one-cycle pulse, at most once per press, after LONG_CYCLES of continuous accepted press.

## Operation
- Per channel: a 2-FF synchroniser feeds the FSM. The synchronised value is normalised to active-high (`p`) by inverting when ACTIVE_LOW=1.
- Synchroniser reset value is the released level: 1 when ACTIVE_LOW=1, else 0. Reset therefore never causes a spurious press.
- db_cnt width is $clog2(DEBOUNCE_CYCLES). hold_cnt width is $clog2(LONG_CYCLES+1). Both are per channel and unsigned.
- FSM states:
  - IDLE: `p`=1 → PRESS_DB, db_cnt←0.
  - PRESS_DB:
    - `p`=0 → IDLE. The glitch is rejected with no output.
    - Else if db_cnt==DEBOUNCE_CYCLES-1 → HELD, key_state←1, key_press pulse, hold_cnt←0.
    - Else db_cnt+1.
  - HELD: `p`=0 → RELEASE_DB, db_cnt←0.
  - RELEASE_DB:
    - `p`=1 → HELD. The bounce is rejected, and hold_cnt is not cleared.
    - Else if db_cnt==DEBOUNCE_CYCLES-1 → IDLE, key_state←0, key_release pulse.
    - Else db_cnt+1.
- hold_cnt increments every cycle in HELD and RELEASE_DB and saturates at LONG_CYCLES.
  - key_long pulses on the cycle hold_cnt transitions LONG_CYCLES-1 → LONG_CYCLES.
  - Saturation guarantees a single pulse per press.
  - When LONG_CYCLES=0, key_long stays 0 and the counter logic is removed.
- key_release is issued regardless of whether key_long fired.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- key_press, key_release and key_long are mutually exclusive within a channel in any cycle.

## Timing
- Reset: all outputs 0, all FSMs IDLE, all counters 0. Reset asserted mid-press drops any pending pulse immediately. No key_release is issued for a press aborted by reset.
- Press latency: key_in goes pressed and stays pressed before rising edge 1.
  - Sync stage 2 holds it after edge 2.
  - The FSM enters PRESS_DB at edge 3.
  - key_press and key_state rise after edge DEBOUNCE_CYCLES+3; key_press lasts exactly one cycle.
- Release latency: same structure. key_release pulses and key_state falls after edge DEBOUNCE_CYCLES+3, counted from the first released sample.
- key_long: asserted after edge DEBOUNCE_CYCLES+3+LONG_CYCLES, counted from the press start, provided the press is unbroken. Bounces shorter than DEBOUNCE_CYCLES during the hold count as held.
- Glitch rejection:
  - A pressed pulse lasting ≤ DEBOUNCE_CYCLES cycles at key_in never produces key_press.
  - A pressed pulse lasting ≥ DEBOUNCE_CYCLES+1 cycles always produces key_press.
  - The same bounds apply to releases.
- All outputs are registered. There is no combinational path from key_in to any output.

## Test plan
Bench settings: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, 10 ns clock.
- Reset release with key_in=2'b11 held → all outputs stay 0 for 50 cycles.
- key_in[0]=0 from edge 1 onward → key_press=2'b01 for exactly one cycle after edge 7, key_state[0]=1 from then on, key_long=2'b01 one cycle after edge 17, no second key_long.
- Bounce sequence on key_in[0]:
  - 3-cycle low, then 2 cycles high, then steady low → single key_press only after the steady low has lasted 4 sync'd cycles.
  - A 3-cycle high glitch while HELD → no key_release, key_long timing unchanged.
- Held key, then key_in[0]=1 steady → key_release=2'b01 one cycle, 7 edges after the release, key_state[0]=0. With a press of only 6 cycles past acceptance, key_release occurs with no key_long.
- Both keys pressed on the same edge → key_press=2'b11 in the same cycle. Keys released 3 cycles apart → separate key_release pulses 3 cycles apart.
- rst_n asserted while channel 0 is in PRESS_DB, deasserted with key still low → no pulse during reset; full 7-edge press latency restarts after reset release.
